// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter granting N CPUs one memory access at a time.
// Completion goes back to the CPU over a 4-phase q/dn handshake, with a timeout on mem_ack.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   cpu_read_q/write_q     per-CPU level requests
//   cpu_addr/cpu_wdata     per-CPU address/data, CPU i at [i*W +: W]
//   cpu_read_dn/write_dn   one-hot done to the granted CPU
//   cpu_rdata, bus_err     read data / timeout flag, valid with *_dn
//   bus_busy, grant_idx    arbiter status
//   mem_*                  single-access memory port
module mem_bus_arbiter #(
  parameter int N_CPU       = 4,
  parameter int IDX_W       = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CPU-1:0]          cpu_read_q,
  input  logic [N_CPU-1:0]          cpu_write_q,
  input  logic [N_CPU*ADDR_W-1:0]   cpu_addr,
  input  logic [N_CPU*DATA_W-1:0]   cpu_wdata,
  output logic [N_CPU-1:0]          cpu_read_dn,
  output logic [N_CPU-1:0]          cpu_write_dn,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic                      bus_err,
  output logic                      bus_busy,
  output logic [IDX_W-1:0]          grant_idx,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_rd,
  output logic                      mem_wr,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_ack
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    RELEASE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   last_grant;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               op_wr;
  logic [N_CPU-1:0]   req;
  logic [N_CPU-1:0]   grant_oh;
  logic [IDX_W-1:0]   pick;
  logic               pick_vld;
  logic [IDX_W-1:0]   cand;
  int                 cand_i;

  assign req      = cpu_read_q | cpu_write_q;
  assign grant_oh = N_CPU'(1) << grant_idx;

  // Scan starts one past the last winner, so a CPU that keeps
  // requesting waits behind every other pending CPU.
  always_comb begin
    pick     = last_grant;
    pick_vld = 1'b0;
    cand_i   = 0;
    cand     = '0;
    for (int k = 1; k <= N_CPU; k++) begin
      cand_i = (int'(last_grant) + k) % N_CPU;
      cand   = IDX_W'(cand_i);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= IDX_W'(N_CPU - 1);
      tmo_cnt      <= '0;
      op_wr        <= 1'b0;
      cpu_read_dn  <= '0;
      cpu_write_dn <= '0;
      cpu_rdata    <= '0;
      bus_err      <= 1'b0;
      bus_busy     <= 1'b0;
      grant_idx    <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            grant_idx  <= pick;
            last_grant <= pick;
            mem_addr   <= cpu_addr[int'(pick)*ADDR_W +: ADDR_W];
            mem_wdata  <= cpu_wdata[int'(pick)*DATA_W +: DATA_W];
            // write has priority when both q lines are up
            op_wr      <= cpu_write_q[pick];
            mem_wr     <= cpu_write_q[pick];
            mem_rd     <= !cpu_write_q[pick];
            tmo_cnt    <= '0;
            bus_busy   <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          // ack checked first so it wins over a same-cycle timeout
          if (mem_ack) begin
            cpu_rdata <= op_wr ? '0 : mem_rdata;
            bus_err   <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            state     <= DONE;
          end else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            cpu_rdata <= '1;
            bus_err   <= 1'b1;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            state     <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          cpu_read_dn  <= op_wr ? '0 : grant_oh;
          cpu_write_dn <= op_wr ? grant_oh : '0;
          state        <= RELEASE;
        end
        RELEASE: begin
          if (!req[grant_idx]) begin
            cpu_read_dn  <= '0;
            cpu_write_dn <= '0;
            cpu_rdata    <= '0;
            bus_err      <= 1'b0;
            bus_busy     <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed vector table plus hand sequences
// for fairness, timeout, reset abort and held handshakes.
module tb_mem_bus_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   cpu_read_q;
  logic [3:0]   cpu_write_q;
  logic [127:0] cpu_addr;
  logic [127:0] cpu_wdata;
  logic [3:0]   cpu_read_dn;
  logic [3:0]   cpu_write_dn;
  logic [31:0]  cpu_rdata;
  logic         bus_err;
  logic         bus_busy;
  logic [1:0]   grant_idx;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_rd;
  logic         mem_wr;
  logic [31:0]  mem_rdata;
  logic         mem_ack;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_read_q   (cpu_read_q),
    .cpu_write_q  (cpu_write_q),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_read_dn  (cpu_read_dn),
    .cpu_write_dn (cpu_write_dn),
    .cpu_rdata    (cpu_rdata),
    .bus_err      (bus_err),
    .bus_busy     (bus_busy),
    .grant_idx    (grant_idx),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  typedef struct {
    logic [3:0]  rq;
    logic [3:0]  wq;
    logic        ack;
    logic [31:0] mrd;
    logic [3:0]  rdn;
    logic [3:0]  wdn;
    logic        cr;
    logic [31:0] rdata;
    logic        err;
    logic        busy;
    logic [1:0]  grant;
    logic        srd;
    logic        swr;
    logic        ca;
    logic [31:0] maddr;
    logic [31:0] mwd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic [3:0] rq, input logic [3:0] wq,
    input logic ack, input logic [31:0] mrd,
    input logic [3:0] rdn, input logic [3:0] wdn,
    input logic cr, input logic [31:0] rdata,
    input logic err, input logic busy,
    input logic [1:0] grant,
    input logic srd, input logic swr,
    input logic ca, input logic [31:0] maddr,
    input logic [31:0] mwd);
    vec_t v;
    v.rq = rq; v.wq = wq; v.ack = ack; v.mrd = mrd;
    v.rdn = rdn; v.wdn = wdn; v.cr = cr; v.rdata = rdata;
    v.err = err; v.busy = busy; v.grant = grant;
    v.srd = srd; v.swr = swr; v.ca = ca;
    v.maddr = maddr; v.mwd = mwd;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    cpu_read_q = '0;
    cpu_write_q = '0;
    mem_ack = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dn"}, {cpu_read_dn, cpu_write_dn}, 0);
    chk({tag, "_busy"}, bus_busy, 0);
    chk({tag, "_strobe"}, {mem_rd, mem_wr}, 0);
    chk({tag, "_err"}, bus_err, 0);
    chk({tag, "_rdata"}, cpu_rdata, 0);
    chk({tag, "_grant"}, grant_idx, 0);
    chk({tag, "_maddr"}, mem_addr, 0);
  endtask

  function automatic logic [31:0] wd(input int i);
    return 32'hA0A0_0000 + 32'(i);
  endfunction

  // One write per CPU while all four request together.
  task automatic serve_write(input int e, input int dly);
    int n;
    n = 0;
    while (!(mem_rd || mem_wr) && n < 20) begin
      n++;
      step();
    end
    chk($sformatf("w%0d_strobe_seen", e), mem_rd || mem_wr, 1);
    chk($sformatf("w%0d_grant", e), grant_idx, 64'(e));
    chk($sformatf("w%0d_op", e), {mem_rd, mem_wr}, 2'b01);
    chk($sformatf("w%0d_wdata", e), mem_wdata, wd(e));
    chk($sformatf("w%0d_addr", e), mem_addr, 64'(e * 128));
    repeat (dly - 1) step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    n = 0;
    while (cpu_write_dn == 0 && n < 10) begin
      n++;
      step();
    end
    chk($sformatf("w%0d_dn", e), cpu_write_dn, 64'(1 << e));
    chk($sformatf("w%0d_busy", e), bus_busy, 1);
    chk($sformatf("w%0d_err", e), bus_err, 0);
    cpu_write_q[e] = 1'b0;
    step();
    chk($sformatf("w%0d_dn_clr", e), {cpu_read_dn, cpu_write_dn}, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int h;
    for (int i = 0; i < 4; i++) begin
      cpu_addr[i*32 +: 32] = 32'(i * 128);
      cpu_wdata[i*32 +: 32] = wd(i);
    end
    mem_rdata = '0;
    do_reset();
    chk_zero("reset");

    // rq wq ack mrd | rdn wdn cr rdata err busy grant rd wr ca maddr mwd
    tbl.push_back(mk(4'h4, 4'h0, 0, 32'h0, 4'h0, 4'h0, 1, 32'h0,
                     0, 1, 2'd2, 1, 0, 1, 32'h100, wd(2)));
    tbl.push_back(mk(4'h4, 4'h0, 0, 32'h0, 4'h0, 4'h0, 0, 32'h0,
                     0, 1, 2'd2, 1, 0, 1, 32'h100, wd(2)));
    tbl.push_back(mk(4'h4, 4'h0, 0, 32'h0, 4'h0, 4'h0, 0, 32'h0,
                     0, 1, 2'd2, 1, 0, 1, 32'h100, wd(2)));
    tbl.push_back(mk(4'h4, 4'h0, 1, 32'hDEADBEEF, 4'h0, 4'h0, 0, 32'h0,
                     0, 1, 2'd2, 0, 0, 0, 32'h0, 32'h0));
    tbl.push_back(mk(4'h4, 4'h0, 0, 32'h0, 4'h4, 4'h0, 1, 32'hDEADBEEF,
                     0, 1, 2'd2, 0, 0, 0, 32'h0, 32'h0));
    tbl.push_back(mk(4'h0, 4'h0, 0, 32'h0, 4'h0, 4'h0, 1, 32'h0,
                     0, 0, 2'd2, 0, 0, 0, 32'h0, 32'h0));
    tbl.push_back(mk(4'h2, 4'h2, 0, 32'h0, 4'h0, 4'h0, 0, 32'h0,
                     0, 1, 2'd1, 0, 1, 1, 32'h80, wd(1)));
    tbl.push_back(mk(4'h2, 4'h2, 1, 32'h12345678, 4'h0, 4'h0, 0, 32'h0,
                     0, 1, 2'd1, 0, 0, 0, 32'h0, 32'h0));
    tbl.push_back(mk(4'h2, 4'h2, 0, 32'h0, 4'h0, 4'h2, 0, 32'h0,
                     0, 1, 2'd1, 0, 0, 0, 32'h0, 32'h0));
    tbl.push_back(mk(4'h2, 4'h2, 0, 32'h0, 4'h0, 4'h2, 0, 32'h0,
                     0, 1, 2'd1, 0, 0, 0, 32'h0, 32'h0));
    tbl.push_back(mk(4'h0, 4'h0, 0, 32'h0, 4'h0, 4'h0, 0, 32'h0,
                     0, 0, 2'd1, 0, 0, 0, 32'h0, 32'h0));
    tbl.push_back(mk(4'h0, 4'h0, 1, 32'h55555555, 4'h0, 4'h0, 1, 32'h0,
                     0, 0, 2'd1, 0, 0, 1, 32'h80, wd(1)));
    tbl.push_back(mk(4'h0, 4'h0, 0, 32'h0, 4'h0, 4'h0, 1, 32'h0,
                     0, 0, 2'd1, 0, 0, 1, 32'h80, wd(1)));

    foreach (tbl[i]) begin
      cpu_read_q = tbl[i].rq;
      cpu_write_q = tbl[i].wq;
      mem_ack = tbl[i].ack;
      mem_rdata = tbl[i].mrd;
      step();
      chk($sformatf("v%0d_rdn", i), cpu_read_dn, tbl[i].rdn);
      chk($sformatf("v%0d_wdn", i), cpu_write_dn, tbl[i].wdn);
      if (tbl[i].cr)
        chk($sformatf("v%0d_rdata", i), cpu_rdata, tbl[i].rdata);
      chk($sformatf("v%0d_err", i), bus_err, tbl[i].err);
      chk($sformatf("v%0d_busy", i), bus_busy, tbl[i].busy);
      chk($sformatf("v%0d_grant", i), grant_idx, tbl[i].grant);
      chk($sformatf("v%0d_strobe", i), {mem_rd, mem_wr},
          {tbl[i].srd, tbl[i].swr});
      if (tbl[i].ca) begin
        chk($sformatf("v%0d_maddr", i), mem_addr, tbl[i].maddr);
        chk($sformatf("v%0d_mwdata", i), mem_wdata, tbl[i].mwd);
      end
    end
    mem_ack = 1'b0;

    // All four write together: served 0,1,2,3.
    do_reset();
    cpu_write_q = 4'hF;
    for (int e = 0; e < 4; e++) serve_write(e, e + 1);
    step();
    chk("w_all_busy_end", bus_busy, 0);
    chk("w_all_idle_strobe", {mem_rd, mem_wr}, 0);

    // Read that never gets an ack.
    cpu_read_q = 4'h8;
    step();
    n = 0;
    while (mem_rd && n < 400) begin
      n++;
      step();
    end
    chk("tmo_access_cycles", n, 255);
    step();
    chk("tmo_rdn", cpu_read_dn, 4'h8);
    chk("tmo_err", bus_err, 1);
    chk("tmo_rdata", cpu_rdata, 32'hFFFF_FFFF);
    chk("tmo_busy", bus_busy, 1);
    cpu_read_q = 4'h0;
    step();
    chk("tmo_clr_dn", cpu_read_dn, 0);
    chk("tmo_clr_err", bus_err, 0);
    chk("tmo_clr_busy", bus_busy, 0);

    // Ack arriving on the final ACCESS cycle beats the timeout.
    cpu_read_q = 4'h1;
    step();
    repeat (254) step();
    chk("race_still_access", mem_rd, 1);
    mem_ack = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    step();
    mem_ack = 1'b0;
    step();
    chk("race_rdn", cpu_read_dn, 4'h1);
    chk("race_err", bus_err, 0);
    chk("race_rdata", cpu_rdata, 32'h0BAD_F00D);
    cpu_read_q = 4'h0;
    step();

    // Reset in the middle of an access.
    cpu_read_q = 4'h4;
    step();
    step();
    chk("rst_mid_access", mem_rd, 1);
    rst = 1'b1;
    cpu_read_q = 4'h0;
    step();
    rst = 1'b0;
    chk_zero("rst_mid");
    step();
    step();
    chk("rst_no_dn", {cpu_read_dn, cpu_write_dn}, 0);
    cpu_read_q = 4'h3;
    step();
    chk("rst_grant0", grant_idx, 0);
    chk("rst_grant0_rd", mem_rd, 1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    chk("rst_dn0", cpu_read_dn, 4'h1);
    cpu_read_q = 4'h2;
    step();
    step();
    chk("rst_grant1", grant_idx, 1);
    chk("rst_grant1_rd", mem_rd, 1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    chk("rst_dn1", cpu_read_dn, 4'h2);
    cpu_read_q = 4'h0;
    step();

    // CPU1 holds read_q for 4 cycles after dn.
    cpu_read_q = 4'h2;
    step();
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    step();
    mem_ack = 1'b0;
    step();
    h = 0;
    for (int c = 0; c < 4; c++) begin
      if (cpu_read_dn == 4'h2 && cpu_rdata == 32'hCAFE_F00D) h++;
      if (c < 3) step();
    end
    chk("hold_dn_cycles", h, 4);
    cpu_read_q = 4'h0;
    step();
    chk("hold_dn_clr", cpu_read_dn, 0);
    chk("hold_busy_clr", bus_busy, 0);
    step();
    chk("hold_idle_strobe", {mem_rd, mem_wr}, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
